full_adder: RTL and testbench

- Synchronous full adder: adds two WIDTH-bit operands plus a carry-in and registers the sum and carry-out.
- Default WIDTH=1 gives the classic 1-bit full adder (ain, bin, cin -> sout, cout).
- Serves as the arithmetic leaf cell for lab datapaths and ripple-carry chains in the Cyclone IV E designs.
- Internally a ripple chain of 1-bit full-adder cells followed by an output register stage with a valid flag.

---
 rtl/full_adder.sv | 90 +++++++++
 tb/tb_full_adder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// Synchronous WIDTH-bit full adder: {cout, sout} = ain + bin + cin.
// A ripple chain of 1-bit full-adder cells feeds an optional output register
// stage; out_valid is always registered from in_valid.
//
// Ports:
//   sys_clk    in   rising-edge clock
//   sys_rst_n  in   synchronous active-low reset
//   in_valid   in   operands valid this cycle
//   ain, bin   in   WIDTH-bit unsigned operands
//   cin        in   carry-in
//   sout       out  WIDTH-bit sum
//   cout       out  carry-out of the MSB cell
//   out_valid  out  sout/cout hold a new result
module full_adder #(
   parameter int unsigned WIDTH   = 1,
   parameter bit          REG_OUT = 1'b1
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] ain,
   input  logic [WIDTH-1:0] bin,
   input  logic             cin,
   output logic [WIDTH-1:0] sout,
   output logic             cout,
   output logic             out_valid
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum;
   logic             valid_q;
   logic             valid_d;

   // Ripple chain of 1-bit cells.
   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = cin;
      for (int i = 0; i < int'(WIDTH); i++) begin
         sum[i]     = ain[i] ^ bin[i] ^ carry[i];
         carry[i+1] = (ain[i] & bin[i]) | (carry[i] & (ain[i] ^ bin[i]));
      end
   end

   assign valid_d = in_valid;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   assign out_valid = valid_q;

   if (REG_OUT) begin : g_reg_out
      logic [WIDTH-1:0] sout_q;
      logic [WIDTH-1:0] sout_d;
      logic             cout_q;
      logic             cout_d;

      // Load only on in_valid so X on idle inputs never reaches the held result.
      always_comb begin
         sout_d = sout_q;
         cout_d = cout_q;
         if (in_valid) begin
            sout_d = sum;
            cout_d = carry[WIDTH];
         end
      end

      always_ff @(posedge sys_clk) begin
         if (!sys_rst_n) begin
            sout_q <= '0;
            cout_q <= 1'b0;
         end else begin
            sout_q <= sout_d;
            cout_q <= cout_d;
         end
      end

      assign sout = sout_q;
      assign cout = cout_q;
   end else begin : g_comb_out
      assign sout = sum;
      assign cout = carry[WIDTH];
   end

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: 1-bit and 8-bit registered instances and a
// 4-bit combinational-output instance sharing one clock and reset.
module tb_full_adder;

   logic clk;
   logic rst_n;

   logic       v1, a1, b1, c1, s1, co1, ov1;
   logic       v8, c8, co8, ov8;
   logic [7:0] a8, b8, s8;
   logic       v4, c4, co4, ov4;
   logic [3:0] a4, b4, s4;

   int n_checks = 0;
   int n_pass   = 0;

   full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
      .sys_clk(clk), .sys_rst_n(rst_n), .in_valid(v1), .ain(a1), .bin(b1), .cin(c1),
      .sout(s1), .cout(co1), .out_valid(ov1)
   );

   full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
      .sys_clk(clk), .sys_rst_n(rst_n), .in_valid(v8), .ain(a8), .bin(b8), .cin(c8),
      .sout(s8), .cout(co8), .out_valid(ov8)
   );

   full_adder #(.WIDTH(4), .REG_OUT(1'b0)) u_w4 (
      .sys_clk(clk), .sys_rst_n(rst_n), .in_valid(v4), .ain(a4), .bin(b4), .cin(c4),
      .sout(s4), .cout(co4), .out_valid(ov4)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] exp1 [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

   initial begin
      rst_n = 1'b0;
      v1 = 0; a1 = 0; b1 = 0; c1 = 0;
      v8 = 0; a8 = 0; b8 = 0; c8 = 0;
      v4 = 0; a4 = 0; b4 = 0; c4 = 0;

      // Reset held for two edges.
      for (int i = 0; i < 2; i++) begin
         step();
         check_eq("rst_w1", {62'd0, co1, s1}, 64'd0);
         check_eq("rst_w1_valid", {63'd0, ov1}, 64'd0);
      end
      rst_n = 1'b1;
      step();
      check_eq("post_rst_w1", {61'd0, ov1, co1, s1}, 64'd0);
      check_eq("post_rst_w8", {55'd0, ov8, co8, s8}, 64'd0);

      // Exhaustive 1-bit.
      for (int i = 0; i < 8; i++) begin
         {a1, b1, c1} = 3'(i);
         v1 = 1'b1;
         step();
         check_eq($sformatf("w1_vec%0d", i), {62'd0, co1, s1}, {62'd0, exp1[i]});
         check_eq($sformatf("w1_vec%0d_valid", i), {63'd0, ov1}, 64'd1);
      end

      // Hold with in_valid low.
      {a1, b1, c1} = 3'b111;
      v1 = 1'b1;
      step();
      check_eq("hold_load", {61'd0, ov1, co1, s1}, 64'b111);
      v1 = 1'b0;
      {a1, b1, c1} = 3'b000;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq($sformatf("hold%0d", i), {61'd0, ov1, co1, s1}, 64'b011);
      end
      a1 = 1'bx;
      b1 = 1'bx;
      step();
      check_eq("hold_x", {61'd0, ov1, co1, s1}, 64'b011);
      a1 = 0;
      b1 = 0;

      // 8-bit vectors.
      v8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
      step();
      check_eq("w8_ff_01", {55'd0, ov8, co8, s8}, {55'd0, 1'b1, 1'b1, 8'h00});
      a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
      step();
      check_eq("w8_ff_ff_1", {55'd0, ov8, co8, s8}, {55'd0, 1'b1, 1'b1, 8'hFF});
      a8 = 8'h35; b8 = 8'h4A; c8 = 1'b1;
      step();
      check_eq("w8_35_4a_1", {55'd0, ov8, co8, s8}, {55'd0, 1'b1, 1'b0, 8'h80});
      a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
      step();
      check_eq("w8_zero", {55'd0, ov8, co8, s8}, {55'd0, 1'b1, 1'b0, 8'h00});
      v8 = 1'b0;

      // Reset on the same edge as a valid input.
      {a1, b1, c1} = 3'b110;
      v1 = 1'b1;
      rst_n = 1'b0;
      step();
      check_eq("mid_rst", {61'd0, ov1, co1, s1}, 64'd0);
      rst_n = 1'b1;
      {a1, b1, c1} = 3'b101;
      step();
      check_eq("after_rst", {61'd0, ov1, co1, s1}, 64'b110);
      v1 = 1'b0;

      // 4-bit combinational outputs, registered valid.
      step();
      a4 = 4'h9; b4 = 4'h8; c4 = 1'b0; v4 = 1'b1;
      #1;
      check_eq("w4_comb", {59'd0, co4, s4}, {59'd0, 1'b1, 4'h1});
      check_eq("w4_valid_lag", {63'd0, ov4}, 64'd0);
      step();
      check_eq("w4_valid_rise", {63'd0, ov4}, 64'd1);
      a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
      #1;
      check_eq("w4_comb_ff", {59'd0, co4, s4}, {59'd0, 1'b1, 4'hF});
      v4 = 1'b0;
      step();
      check_eq("w4_valid_fall", {63'd0, ov4}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
